// File: rtl/imem_boot_controller.sv
// Boot-time loader for the instruction memory port: streams a program in byte by byte, then hands the port to the CPU.
// Optional trailing checksum byte is enabled by defining IMEM_CHECKSUM_EN.
module imem_boot_controller #(
  parameter int MEM_BYTES = 8192,
  parameter int ADDR_W    = 32,
  parameter int BOOT_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_stall,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_W-1:0] BOOT      = ADDR_W'(BOOT_ADDR);
  localparam logic [ADDR_W-1:0] MAX_LEN   = ADDR_W'(MEM_BYTES - BOOT_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] start_len;
  logic              pend_we;
  logic [7:0]        pend_data;
  logic              start;
  logic              accept;
  logic              wr_accept;
  logic              finish;
  logic              done_next;
  logic              cks_pending;
  logic              sum_ok;

  // The length clamp is what keeps the write pointer from running past the end of memory.
  assign start_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign start     = load_start && (state != LOAD);
  assign accept    = byte_valid && byte_ready;
  assign wr_accept = accept && (count != '0);
  assign finish    = (count == '0) && !cks_pending;

`ifdef IMEM_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;

  logic [7:0] sum;
  logic       err_next;

  assign sum_ok   = (sum == 8'd0);
  assign err_next = (state == LOAD) && finish && !sum_ok;

  // The checksum byte is the one accepted once the payload count has reached zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cks_pending <= 1'b0;
      sum         <= 8'd0;
      load_err    <= 1'b0;
    end else begin
      if (start) begin
        cks_pending <= 1'b1;
        sum         <= 8'd0;
      end else if (accept) begin
        sum <= sum + byte_data;
        if (count == '0) cks_pending <= 1'b0;
      end
      if (start) load_err <= 1'b0;
      else if (err_next) load_err <= 1'b1;
    end
  end
`else
  localparam bit CKS_EN = 1'b0;

  assign cks_pending = 1'b0;
  assign sum_ok      = 1'b1;
  assign load_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (load_start) begin
          if ((start_len == '0) && !CKS_EN) begin
            state_next = RUN;
            done_next  = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (finish) begin
          if (sum_ok) begin
            state_next = RUN;
            done_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accepted bytes are written one cycle later; the pointer advances as each write is issued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr       <= BOOT;
      count     <= '0;
      pend_we   <= 1'b0;
      pend_data <= 8'd0;
      load_done <= 1'b0;
    end else begin
      load_done <= done_next;
      pend_we   <= wr_accept;
      if (wr_accept) begin
        pend_data <= byte_data;
        count     <= count - 1'b1;
      end
      if (start) begin
        ptr   <= BOOT;
        count <= start_len;
      end else if (pend_we) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign byte_ready  = (state == LOAD) && ((count != '0) || cks_pending);
  assign mem_we      = pend_we;
  assign mem_wdata   = pend_data;
  assign mem_addr    = (state == LOAD) ? ptr : cpu_pc;
  assign cpu_stall   = (state != RUN);
  assign busy        = (state == LOAD);
  assign fetch_fault = (state == RUN) && ((cpu_pc[1:0] != 2'b00) || (cpu_pc > LAST_WORD));

endmodule

// File: tb/tb_imem_boot_controller.sv
// Directed-plus-random bench for imem_boot_controller; a shadow memory and write log stand in for the instruction RAM.
// Checksum expectations follow IMEM_CHECKSUM_EN when that macro is defined for the build.
module tb_imem_boot_controller;

  localparam int MEM_BYTES = 8192;
  localparam int ADDR_W    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_start;
  logic [ADDR_W-1:0] load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] cpu_pc;
  logic              cpu_stall;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic              fetch_fault;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;

  logic [7:0]        imem [0:MEM_BYTES-1];
  logic [ADDR_W-1:0] wr_addrs[$];
  logic [7:0]        wr_data[$];
  logic [7:0]        payload[$];

  imem_boot_controller #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W),
    .BOOT_ADDR(0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .cpu_pc     (cpu_pc),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // Plays the role of the instruction RAM and records every write the controller issues.
  always @(posedge clock) begin
    if (mem_we === 1'b1) begin
      imem[mem_addr[12:0]] <= mem_wdata;
      wr_addrs.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (load_done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Counts log entries or memory bytes that disagree with the expected image at addresses 0..n-1.
  function automatic int log_errors(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= wr_addrs.size()) bad++;
      else if (wr_addrs[i] !== 32'(i) || wr_data[i] !== payload[i] || imem[i] !== payload[i]) bad++;
    end
    return bad;
  endfunction

  // Runs one load of the current payload; valid_mode 0=back-to-back, 1=every other cycle, 2=random with stray load_start.
  task automatic applyStimulus(input logic [31:0] req_len, input int valid_mode, input int abort_after, input bit corrupt);
    int         total;
    int         idx;
    int         cyc;
    int         limit;
    bit         acc;
    bit         exp_ok;
    logic [7:0] stream[$];
    logic [7:0] sum;
    idx    = 0;
    cyc    = 0;
    sum    = 8'd0;
    exp_ok = !corrupt;
    stream = payload;
`ifdef IMEM_CHECKSUM_EN
    foreach (payload[i]) sum = sum + payload[i];
    stream.push_back(corrupt ? (8'd1 - sum) : (8'd0 - sum));
`endif
    total = stream.size();
    limit = total * 3 + 20;
    wr_addrs.delete();
    wr_data.delete();
    done_count = 0;
    load_start = 1'b1;
    load_len   = req_len;
    @(posedge clock); #1;
    load_start = 1'b0;
    load_len   = $urandom;
    checkOutput("stall_after_start", cpu_stall, 1);
    checkOutput("busy_after_start", busy, 1);
    while (idx < total && cyc < limit) begin
      case (valid_mode)
        0: byte_valid = 1'b1;
        1: byte_valid = (cyc % 2 == 0);
        default: begin
          byte_valid = 1'($urandom_range(0, 1));
          load_start = 1'($urandom_range(0, 1));
        end
      endcase
      byte_data = stream[idx];
      #1;
      checkOutput("byte_ready_load", byte_ready, 1);
      acc = byte_valid && byte_ready;
      @(posedge clock); #1;
      cyc++;
      if (acc) idx++;
      if (abort_after > 0 && idx == abort_after) begin
        load_start = 1'b0;
        return;
      end
    end
    load_start = 1'b0;
    byte_valid = 1'b0;
    checkOutput("load_finished_in_budget", idx, total);
    #1;
    checkOutput("byte_ready_after_last", byte_ready, 0);
    checkOutput("busy_final_cycle", busy, 1);
    @(posedge clock); #1;
    checkOutput("load_done_pulse", load_done, exp_ok);
    checkOutput("stall_after_load", cpu_stall, !exp_ok);
    checkOutput("busy_after_load", busy, 0);
    checkOutput("load_err", load_err, !exp_ok);
    @(posedge clock); #1;
    checkOutput("load_done_single", load_done, 0);
    checkOutput("done_count", done_count, exp_ok);
    checkOutput("write_count", wr_addrs.size(), payload.size());
    checkOutput("write_content_errors", log_errors(payload.size()), 0);
  endtask

  initial begin
    logic [31:0] pcs[$];
    logic [31:0] pc;
    bit          exp_ff;

    reset      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    cpu_pc     = 32'd0;

    // Reset held for two cycles, then released into IDLE.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_cpu_stall", cpu_stall, 1);
    checkOutput("rst_byte_ready", byte_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_load_err", load_err, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    cpu_pc = 32'd6;
    #1;
    checkOutput("idle_mem_addr", mem_addr, 6);
    checkOutput("idle_fetch_fault", fetch_fault, 0);
    checkOutput("idle_stall", cpu_stall, 1);

    // Fixed program, streamed back-to-back.
    payload = '{8'h20, 8'h08, 8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h02};
    applyStimulus(32'd8, 0, 0, 1'b0);
    cpu_pc = 32'd4;
    #1;
    checkOutput("run_mem_addr_4", mem_addr, 4);
    checkOutput("run_mem_we", mem_we, 0);

    // Fetch-fault rule: misaligned, or a word that would extend past the end of memory.
    pcs = '{32'd6, 32'd8190, 32'd8, 32'd8188, 32'd8189, 32'd8192, 32'd0, 32'hFFFF_FFFC};
    for (int i = 0; i < 20; i++) pcs.push_back(32'($urandom_range(0, 8300)));
    foreach (pcs[i]) begin
      pc     = pcs[i];
      cpu_pc = pc;
      #1;
      exp_ff = (pc % 4 != 0) || (longint'(pc) + 4 > MEM_BYTES);
      checkOutput("fetch_fault", fetch_fault, exp_ff);
      checkOutput("run_mem_addr", mem_addr, pc);
      @(posedge clock); #1;
    end

    // Same program reloaded from RUN with byte_valid toggling.
    applyStimulus(32'd8, 1, 0, 1'b0);

    // Reset arrives after three bytes have been accepted.
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    applyStimulus(32'd8, 0, 3, 1'b0);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    checkOutput("abort_stall", cpu_stall, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_byte_ready", byte_ready, 0);
    reset      = 1'b1;
    byte_valid = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    checkOutput("abort_write_count", wr_addrs.size(), 3);
    checkOutput("abort_write_errors", log_errors(3), 0);
    checkOutput("abort_idle_stall", cpu_stall, 1);

    payload.delete();
    for (int i = 0; i < 4; i++) payload.push_back(8'($urandom));
    applyStimulus(32'd4, 2, 0, 1'b0);

`ifndef IMEM_CHECKSUM_EN
    // Zero-length load goes straight to RUN with a done pulse.
    wr_addrs.delete();
    load_start = 1'b1;
    load_len   = 32'd0;
    @(posedge clock); #1;
    load_start = 1'b0;
    checkOutput("zero_len_done", load_done, 1);
    checkOutput("zero_len_stall", cpu_stall, 0);
    checkOutput("zero_len_busy", busy, 0);
    @(posedge clock); #1;
    checkOutput("zero_len_done_single", load_done, 0);
    checkOutput("zero_len_writes", wr_addrs.size(), 0);
`else
    // Payload 01,02 with a good checksum, then with a bad one.
    payload = '{8'h01, 8'h02};
    applyStimulus(32'd2, 0, 0, 1'b0);
    applyStimulus(32'd2, 0, 0, 1'b1);
    payload.delete();
    applyStimulus(32'd0, 0, 0, 1'b0);
`endif

    // Random-length loads with random handshakes.
    for (int n = 0; n < 3; n++) begin
      payload.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) payload.push_back(8'($urandom));
      applyStimulus(32'(payload.size()), 2, 0, 1'b0);
    end

    // An oversized length is clamped to the whole memory.
    payload.delete();
    for (int i = 0; i < MEM_BYTES; i++) payload.push_back(8'($urandom));
    applyStimulus(32'hFFFF_FFFF, 0, 0, 1'b0);
    cpu_pc = 32'd8188;
    #1;
    checkOutput("clamp_last_word_fault", fetch_fault, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
- Sequences the single port of the byte-addressed instruction memory between a program loader and the CPU fetch path.
- After reset the CPU is held stalled while a program is streamed in one byte per handshake and written at consecutive byte addresses starting at BOOT_ADDR.
- When loading completes, the memory address mux is handed to the CPU PC and the stall is released.
- Replaces the file-based image preload for synthesizable targets.

Parameters:
MEM_BYTES, 8192, instruction memory size in bytes
ADDR_W, 32, address width
BOOT_ADDR, 0, first byte address written by a load

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
load_start  in  1  single-cycle request to begin a load
load_len  in  ADDR_W  payload length in bytes, sampled with load_start
byte_valid  in  1  loader byte available
byte_data  in  8  loader byte
byte_ready  out  1  controller accepts byte this cycle
mem_addr  out  ADDR_W  instruction memory address
mem_we  out  1  byte write enable
mem_wdata  out  8  byte write data
cpu_pc  in  ADDR_W  CPU fetch address
cpu_stall  out  1  CPU must not advance PC
busy  out  1  load in progress
load_done  out  1  one-cycle pulse, load finished successfully
load_err  out  1  sticky, load failed (checksum); cleared by next load_start or reset
fetch_fault  out  1  fetch address misaligned or out of range

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - byte_ready=0, mem_we=0, mem_wdata=0, busy=0, load_done=0, load_err=0, cpu_stall=1, internal write pointer=BOOT_ADDR, remaining count=0.
  - Memory contents are untouched.
- IDLE:
  - cpu_stall=1; mem_addr=cpu_pc.
  - load_start=1: latch len=min(load_len, MEM_BYTES-BOOT_ADDR), pointer=BOOT_ADDR, clear load_err, go to LOAD.
  - If the latched len==0 (and IMEM_CHECKSUM_EN is undefined), go directly to RUN with load_done pulsed the next cycle.
- LOAD:
  - busy=1, cpu_stall=1, byte_ready=1 while bytes remain.
  - Byte accepted when byte_valid & byte_ready.
  - Write is registered with latency 1: in the following cycle mem_we=1, mem_addr=pointer, mem_wdata=accepted byte.
  - Pointer then increments by 1 and the count decrements.
  - mem_we=0 and mem_addr=pointer in cycles with no accepted byte.
  - Bytes within a word are written in big-endian order: the first streamed byte goes to the lowest address, which is the MSB of the fetched word.
  - After the last byte is accepted, byte_ready=0 from the next cycle. The final write is issued, then state goes to RUN.
  - load_done=1 for exactly the first RUN cycle; cpu_stall=0 in that same cycle.
  - load_start during LOAD is ignored.
- RUN:
  - cpu_stall=0, busy=0, byte_ready=0, mem_we=0, mem_addr=cpu_pc (combinational, no added latency).
  - load_start=1 starts a reload: stall=1 and the LOAD entry from the next cycle, as in IDLE.
- fetch_fault:
  - Combinational, valid only in RUN, otherwise 0.
  - Asserted when cpu_pc[1:0]!=0 or cpu_pc>MEM_BYTES-4.
  - Informational only; does not change state.
- Reset mid-LOAD: abort immediately; the partially written image remains, and the CPU stays stalled in IDLE.
- Width rules: pointer and count are ADDR_W bits; no wrap past MEM_BYTES-1 because of the length clamp.

Optional Feature:
IMEM_CHECKSUM_EN
- Defined:
  - One extra checksum byte is accepted after the payload; it is not written to memory.
  - An 8-bit modulo-256 sum of payload plus checksum byte is computed.
  - Sum==0: RUN with a load_done pulse.
  - Sum!=0: IDLE with load_err=1, no load_done, cpu_stall held at 1.
  - len==0 still expects the checksum byte.
- Undefined: no trailing byte, load_err is constant 0, and no sum logic is present.

Test Plan:
- Reset held 2 cycles, then released → cpu_stall=1, byte_ready=0, mem_we=0, busy=0, load_done=0, state IDLE.
- load_start with load_len=8, bytes 0x20,0x08,0x00,0x02,0x20,0x09,0x00,0x02 streamed back-to-back:
  - writes to addresses 0..7, each one cycle after acceptance;
  - load_done pulses once; cpu_stall drops;
  - cpu_pc=4 then drives mem_addr=4.
- Same load with byte_valid toggling every other cycle → identical memory writes, no duplicate or skipped addresses, byte_ready stays 1 until the 8th byte is accepted.
- Reset asserted after 3 bytes accepted → IDLE, cpu_stall=1, no further writes; a new load_start with load_len=4 writes addresses 0..3 correctly.
- In RUN, cpu_pc=6, then 8190, then 8 → fetch_fault=1, 1, 0; load_start in RUN → cpu_stall=1 next cycle and byte_ready=1.
- With IMEM_CHECKSUM_EN: payload 0x01,0x02 plus checksum 0xFD → load_done pulse; payload 0x01,0x02 plus 0x00 → load_err=1, cpu_stall stays 1, no load_done.
